wb_arbiter: RTL and testbench



---
 rtl/core_pkg.sv | 27 ++
 rtl/wb_arbiter_load_align.sv | 57 +++++
 rtl/wb_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions used by the writeback stage and its helpers:
// default datapath widths, load funct3 encodings, writeback source tags
// and the long-latency starvation FSM states.
package core_pkg;

  localparam int XLEN_DEF           = 32;
  localparam int REG_ADDR_WIDTH_DEF = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_PIPE = 2'd1,
    WB_LU   = 2'd2
  } wb_src_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } starv_state_e;

endpackage

// File: rtl/wb_arbiter_load_align.sv
// load_align: combinational load lane extraction and sign/zero extension.
// Flags halfword/word accesses whose byte offset breaks natural alignment.
// Also used by the store/debug path, so it carries no state.
module load_align
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  output logic [XLEN-1:0] value,
  output logic            misaligned
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and halfword lanes of the raw word.
  always_comb begin
    case (byte_off)
      2'd0:    byte_s = data[7:0];
      2'd1:    byte_s = data[15:8];
      2'd2:    byte_s = data[23:16];
      2'd3:    byte_s = data[31:24];
      default: byte_s = data[7:0];
    endcase
    if (byte_off[1]) begin
      half_s = data[31:16];
    end else begin
      half_s = data[15:0];
    end
  end

  // Extend the selected lane by load type; unknown types behave as LW.
  always_comb begin
    value      = data;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:   value = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_s};
      F3_LH: begin
        value      = {{(XLEN-16){half_s[15]}}, half_s};
        misaligned = byte_off[0];
      end
      F3_LHU: begin
        value      = {{(XLEN-16){1'b0}}, half_s};
        misaligned = byte_off[0];
      end
      default: begin
        value      = data;
        misaligned = (byte_off != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage merging the in-order MEM result and the
// long-latency (mul/div) result into one registered regfile write, which is
// also exported as a forwarding entry. The MEM stage always wins; a
// starvation FSM raises stall_req once the long-latency unit has been
// blocked LU_WAIT_MAX consecutive cycles.
// Optional build macro: WB_RETIRE_CNT_EN adds a 64-bit retire_cnt output.
module wb_arbiter
  import core_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int LU_WAIT_MAX    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pipe_valid,
  input  logic                      pipe_we,
  input  logic [REG_ADDR_WIDTH-1:0] pipe_rd_addr,
  input  logic [XLEN-1:0]           pipe_data,
  input  logic                      pipe_is_load,
  input  logic [2:0]                pipe_funct3,
  input  logic [1:0]                pipe_byte_off,
  input  logic                      lu_valid,
  output logic                      lu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] lu_rd_addr,
  input  logic [XLEN-1:0]           lu_data,
  output logic                      stall_req,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [XLEN-1:0]           rd_data,
  output logic                      write_en,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_addr,
  output logic [XLEN-1:0]           fwd_data,
  output logic                      misalign_err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]               retire_cnt
`endif
);

  localparam logic [3:0] WAIT_MAX_C = 4'(LU_WAIT_MAX);

  logic                      pipe_slot_s;
  logic                      lu_xfer_s;
  logic [XLEN-1:0]           load_val_s;
  logic                      load_mis_s;
  wb_src_e                   wb_src_s;
  logic [REG_ADDR_WIDTH-1:0] win_addr_s;
  logic [XLEN-1:0]           win_data_s;
  logic                      win_mis_s;
  starv_state_e              state_r;
  starv_state_e              state_s;
  logic [3:0]                wait_cnt_r;
  logic [3:0]                wait_cnt_s;

  assign pipe_slot_s = pipe_valid & pipe_we;
  // Held low during reset so a pending LU result is never taken then.
  assign lu_ready    = lu_valid & ~pipe_slot_s & ~rst;
  assign lu_xfer_s   = lu_valid & lu_ready;

  load_align #(.XLEN(XLEN)) u_load_align (
    .data       (pipe_data),
    .funct3     (pipe_funct3),
    .byte_off   (pipe_byte_off),
    .value      (load_val_s),
    .misaligned (load_mis_s)
  );

  // Pick the writeback winner and the value it would write.
  always_comb begin
    wb_src_s   = WB_NONE;
    win_addr_s = {REG_ADDR_WIDTH{1'b0}};
    win_data_s = {XLEN{1'b0}};
    win_mis_s  = 1'b0;
    if (pipe_slot_s) begin
      wb_src_s   = WB_PIPE;
      win_addr_s = pipe_rd_addr;
      win_mis_s  = pipe_is_load & load_mis_s;
      if (pipe_is_load) begin
        win_data_s = load_val_s;
      end else begin
        win_data_s = pipe_data;
      end
    end else if (lu_xfer_s) begin
      wb_src_s   = WB_LU;
      win_addr_s = lu_rd_addr;
      win_data_s = lu_data;
    end else begin
      wb_src_s   = WB_NONE;
    end
  end

  // Starvation FSM next state and blocked-cycle counter.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    case (state_r)
      IDLE: begin
        if (lu_valid && pipe_slot_s) begin
          wait_cnt_s = 4'd1;
          if (4'd1 >= WAIT_MAX_C) begin
            state_s = FORCE;
          end else begin
            state_s = WAIT;
          end
        end else begin
          wait_cnt_s = 4'd0;
          state_s    = IDLE;
        end
      end
      WAIT: begin
        if (!lu_valid || lu_xfer_s) begin
          wait_cnt_s = 4'd0;
          state_s    = IDLE;
        end else begin
          wait_cnt_s = wait_cnt_r + 4'd1;
          if (wait_cnt_s >= WAIT_MAX_C) begin
            state_s = FORCE;
          end else begin
            state_s = WAIT;
          end
        end
      end
      FORCE: begin
        if (lu_xfer_s) begin
          wait_cnt_s = 4'd0;
          state_s    = IDLE;
        end else begin
          wait_cnt_s = wait_cnt_r;
          state_s    = FORCE;
        end
      end
      default: begin
        wait_cnt_s = 4'd0;
        state_s    = IDLE;
      end
    endcase
  end

  // Starvation FSM state, counter and registered stall request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      wait_cnt_r <= 4'd0;
      stall_req  <= 1'b0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      stall_req  <= (state_s == FORCE);
    end
  end

  // Register the winning write; a misaligned load becomes an error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr      <= {REG_ADDR_WIDTH{1'b0}};
      rd_data      <= {XLEN{1'b0}};
      write_en     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      write_en     <= (wb_src_s != WB_NONE) && !win_mis_s;
      misalign_err <= win_mis_s;
      if (wb_src_s != WB_NONE) begin
        rd_addr <= win_addr_s;
        rd_data <= win_data_s;
      end else begin
        rd_addr <= rd_addr;
        rd_data <= rd_data;
      end
    end
  end

  assign fwd_addr  = rd_addr;
  assign fwd_data  = rd_data;
  assign fwd_valid = write_en & (rd_addr != {REG_ADDR_WIDTH{1'b0}});

`ifdef WB_RETIRE_CNT_EN
  // Retired-instruction count: one per MEM instruction, one per LU transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= 64'd0;
    end else begin
      retire_cnt <= retire_cnt + {63'd0, pipe_valid} + {63'd0, lu_xfer_s};
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter with directed corner cases.
module tb_wb_arbiter;

  localparam int WMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid, pipe_we, pipe_is_load;
  logic [4:0]  pipe_rd_addr;
  logic [31:0] pipe_data;
  logic [2:0]  pipe_funct3;
  logic [1:0]  pipe_byte_off;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_rd_addr;
  logic [31:0] lu_data;
  logic        stall_req, write_en, fwd_valid, misalign_err;
  logic [4:0]  rd_addr, fwd_addr;
  logic [31:0] rd_data, fwd_data;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  typedef struct {
    bit          mis;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          run = 0;            // consecutive cycles the pending LU result was refused
  logic [63:0] retire_m = 64'd0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(32), .REG_ADDR_WIDTH(5), .LU_WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_we(pipe_we), .pipe_rd_addr(pipe_rd_addr),
    .pipe_data(pipe_data), .pipe_is_load(pipe_is_load), .pipe_funct3(pipe_funct3),
    .pipe_byte_off(pipe_byte_off),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd_addr(lu_rd_addr), .lu_data(lu_data),
    .stall_req(stall_req), .rd_addr(rd_addr), .rd_data(rd_data), .write_en(write_en),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
`ifdef WB_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .misalign_err(misalign_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference load semantics expressed as shifts and masks on the word.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off, output bit mis);
    logic [31:0] v;
    int          sh;
    sh  = 8 * int'(off);
    mis = 1'b0;
    if (f3 == 3'b000 || f3 == 3'b100) begin
      v = (w >> sh) & 32'h0000_00FF;
      if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (f3 == 3'b001 || f3 == 3'b101) begin
      mis = off[0];
      v = (w >> sh) & 32'h0000_FFFF;
      if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      mis = (off != 2'd0);
      v = w;
    end
    return v;
  endfunction

  // One clock of stimulus: drive, check combinational/status outputs, predict the write.
  task automatic step(input bit pv, input bit pwe, input logic [4:0] prd, input logic [31:0] pd,
                      input bit pl, input logic [2:0] f3, input logic [1:0] off,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
    bit          slot, mis;
    logic [31:0] v;
    exp_t        e;
    @(posedge clk); #1;
    pipe_valid = pv; pipe_we = pwe; pipe_rd_addr = prd; pipe_data = pd;
    pipe_is_load = pl; pipe_funct3 = f3; pipe_byte_off = off;
    lu_valid = lv; lu_rd_addr = lrd; lu_data = ld;
    @(negedge clk);
    slot = pv & pwe;
    chk("lu_ready", {63'd0, lu_ready}, {63'd0, lv & ~slot});
    chk("stall_req", {63'd0, stall_req}, {63'd0, run >= WMAX});
`ifdef WB_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, retire_m);
    retire_m = retire_m + {63'd0, pv} + {63'd0, lv & ~slot};
`endif
    if (slot) begin
      mis = 1'b0;
      if (pl) v = ref_load(pd, f3, off, mis);
      else    v = pd;
      e.mis = mis; e.addr = prd; e.data = v;
      sb.push_back(e);
    end else if (lv) begin
      e.mis = 1'b0; e.addr = lrd; e.data = ld;
      sb.push_back(e);
    end
    if (lv && slot) run++;
    else run = 0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d, input bit lv);
    step(1'b1, 1'b1, rd, d, 1'b0, 3'd0, 2'd0, lv, 5'd7, 32'h0000_00AA);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [1:0] off);
    step(1'b1, 1'b1, 5'd9, 32'h80FF_7F01, 1'b1, f3, off, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: every registered write or error pulse must match the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (write_en || misalign_err)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output write_en=%0d misalign_err=%0d required=none",
                 write_en, misalign_err);
      end else begin
        e = sb.pop_front();
        chk("misalign_err", {63'd0, misalign_err}, {63'd0, e.mis});
        if (e.mis) begin
          chk("write_en_suppressed", {63'd0, write_en}, 64'd0);
        end else begin
          chk("rd_addr", {59'd0, rd_addr}, {59'd0, e.addr});
          chk("rd_data", {32'd0, rd_data}, {32'd0, e.data});
          chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, e.addr != 5'd0});
          chk("fwd_addr", {59'd0, fwd_addr}, {59'd0, e.addr});
          chk("fwd_data", {32'd0, fwd_data}, {32'd0, e.data});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          lpend;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    rst = 1'b1;
    pipe_valid = 1'b0; pipe_we = 1'b0; pipe_rd_addr = 5'd0; pipe_data = 32'd0;
    pipe_is_load = 1'b0; pipe_funct3 = 3'd0; pipe_byte_off = 2'd0;
    lu_valid = 1'b0; lu_rd_addr = 5'd0; lu_data = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_write_en", {63'd0, write_en}, 64'd0);
    chk("reset_rd_addr", {59'd0, rd_addr}, 64'd0);
    chk("reset_rd_data", {32'd0, rd_data}, 64'd0);
    chk("reset_stall_fwd_mis", {61'd0, stall_req, fwd_valid, misalign_err}, 64'd0);
    rst = 1'b0;

    // ALU write, then the five load extraction cases.
    alu(5'd5, 32'h1234_5678, 1'b0);
    ld(3'b000, 2'd1);
    ld(3'b000, 2'd3);
    ld(3'b101, 2'd2);
    ld(3'b001, 2'd2);
    ld(3'b010, 2'd2);
    idle();
    idle();

    // LU blocked by ten pipe writes, then accepted on the bubble.
    for (int i = 1; i <= 10; i++) alu(5'(i), 32'(i * 3), 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b1, 5'd7, 32'h0000_00AA);
    idle();
    idle();

    // x0 write is performed but not forwarded.
    alu(5'd0, 32'hFFFF_FFFF, 1'b0);
    idle();

    // Asynchronous reset while in FORCE with the LU still offering.
    for (int i = 0; i < 6; i++) alu(5'd3, 32'h0000_0033, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_stall_req", {63'd0, stall_req}, 64'd0);
    chk("rst_write_en", {63'd0, write_en}, 64'd0);
    chk("rst_lu_ready", {63'd0, lu_ready}, 64'd0);
    sb.delete();
    run = 0;
    retire_m = 64'd0;
    @(negedge clk);
    lu_valid = 1'b0; pipe_valid = 1'b0; pipe_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Two pipe writes, then a non-writing pipe cycle with a concurrent LU transfer.
    alu(5'd4, 32'h0000_0044, 1'b0);
    alu(5'd6, 32'h0000_0066, 1'b0);
    step(1'b1, 1'b0, 5'd8, 32'd0, 1'b0, 3'd0, 2'd0, 1'b1, 5'd11, 32'hC0DE_0011);
    idle();
`ifdef WB_RETIRE_CNT_EN
    chk("retire_cnt_four", retire_cnt, 64'd4);
`endif

    // Randomized traffic with a well-behaved LU that holds its offer.
    lpend = 1'b0; lrd = 5'd0; ldat = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      bit         pv, pwe, pl;
      logic [2:0] f3;
      logic [1:0] off;
      if (!lpend && $urandom_range(0, 2) == 0) begin
        lpend = 1'b1;
        lrd   = 5'($urandom);
        ldat  = $urandom;
      end
      pv  = ($urandom_range(0, 9) < 7);
      if (run >= WMAX && $urandom_range(0, 1) == 0) pv = 1'b0;
      pwe = ($urandom_range(0, 3) != 0);
      pl  = ($urandom_range(0, 1) == 0);
      f3  = 3'($urandom);
      off = 2'($urandom);
      step(pv, pwe, 5'($urandom), $urandom, pl, f3, off, lpend, lrd, ldat);
      if (lpend && !(pv && pwe)) lpend = 1'b0;
    end
    idle();
    idle();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
